// File: rtl/bitmem_pkg.sv
// rtl/bitmem_pkg.sv - shared widths and loader state encoding for the 16x1 bit memory
package bitmem_pkg;

   localparam int BITMEM_ADDR_W = 4;
   localparam int BITMEM_WORD_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      CHECK = 2'd2
   } bitmem_loader_state_e;

endpackage

// File: rtl/bitmem_loader.sv
// rtl/bitmem_loader.sv - serialises a masked word into one bit-memory write per cycle
// Optional read-back check of every written bit when BITMEM_LOADER_VERIFY_EN is defined.
module bitmem_loader
   import bitmem_pkg::*;
#(
   parameter int ADDR_W = BITMEM_ADDR_W,
   parameter int WORD_W = 2**ADDR_W
) (
   input  logic              clk,
   input  logic              rst_ni,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [WORD_W-1:0] in_data_i,
   input  logic [WORD_W-1:0] in_mask_i,
   output logic              wen_o,
   output logic [ADDR_W-1:0] waddr_o,
   output logic              wdata_o,
   output logic              busy_o,
`ifdef BITMEM_LOADER_VERIFY_EN
   output logic [ADDR_W-1:0] raddr_o,
   input  logic              rdata_i,
   output logic              err_o,
`endif
   output logic              done_o
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WORD_W - 1);

   bitmem_loader_state_e state_q;
   logic [ADDR_W-1:0]    cnt_q;
   logic [WORD_W-1:0]    data_q;
   logic [WORD_W-1:0]    mask_q;
   logic                 done_q;
   logic                 last;

   assign last = (cnt_q == LAST);

`ifdef BITMEM_LOADER_VERIFY_EN
   logic err_q;
   logic mismatch;

   // Only bits the word actually wrote are expected to match.
   assign mismatch = mask_q[cnt_q] && (rdata_i != data_q[cnt_q]);
`endif

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
         mask_q  <= '0;
         done_q  <= 1'b0;
`ifdef BITMEM_LOADER_VERIFY_EN
         err_q   <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (in_valid_i) begin
                  data_q  <= in_data_i;
                  mask_q  <= in_mask_i;
                  cnt_q   <= '0;
                  state_q <= WRITE;
`ifdef BITMEM_LOADER_VERIFY_EN
                  err_q   <= 1'b0;
`endif
               end
            end
            WRITE: begin
               cnt_q <= cnt_q + ADDR_W'(1);
               if (last) begin
`ifdef BITMEM_LOADER_VERIFY_EN
                  state_q <= CHECK;
`else
                  state_q <= IDLE;
                  done_q  <= 1'b1;
`endif
               end
            end
`ifdef BITMEM_LOADER_VERIFY_EN
            CHECK: begin
               cnt_q <= cnt_q + ADDR_W'(1);
               if (mismatch) begin
                  err_q <= 1'b1;
               end
               if (last) begin
                  state_q <= IDLE;
                  done_q  <= 1'b1;
               end
            end
`endif
            default: state_q <= IDLE;
         endcase
      end
   end

   // Every output is a decode of registered state; the async reset therefore drops wen_o at once.
   assign in_ready_o = (state_q == IDLE);
   assign busy_o     = (state_q != IDLE);
   assign wen_o      = (state_q == WRITE) && mask_q[cnt_q];
   assign waddr_o    = (state_q == WRITE) ? cnt_q : '0;
   assign wdata_o    = (state_q == WRITE) && data_q[cnt_q];
   assign done_o     = done_q;

`ifdef BITMEM_LOADER_VERIFY_EN
   assign raddr_o = (state_q == CHECK) ? cnt_q : '0;
   assign err_o   = err_q;
`endif

endmodule

// File: tb/tb_bitmem_loader.sv
// tb/tb_bitmem_loader.sv - self-checking bench for bitmem_loader driving a 16x1 bit memory
`timescale 1ns/1ps
module tb_bitmem_loader;

   localparam int AW = 4;
   localparam int WW = 16;
`ifdef BITMEM_LOADER_VERIFY_EN
   localparam int LAT    = 33;
   localparam bit VERIFY = 1'b1;
`else
   localparam int LAT    = 17;
   localparam bit VERIFY = 1'b0;
`endif

   typedef struct packed {
      logic          ready;
      logic          busy;
      logic          wen;
      logic [AW-1:0] waddr;
      logic          wdata;
      logic [AW-1:0] raddr;
      logic          done;
      logic          chk_err;
      logic          err;
   } rec_t;

   logic          clk = 1'b0;
   logic          rst_ni = 1'b0;
   logic          in_valid_i = 1'b0;
   logic          in_ready_o;
   logic [WW-1:0] in_data_i = '0;
   logic [WW-1:0] in_mask_i = '0;
   logic          wen_o;
   logic [AW-1:0] waddr_o;
   logic          wdata_o;
   logic          busy_o;
   logic          done_o;
   logic [AW-1:0] got_raddr;
   logic          got_err;

   logic [WW-1:0] mem = '0;
   logic [WW-1:0] ref_mem = '0;
   logic          corrupt_en = 1'b0;
   logic [AW-1:0] corrupt_addr = '0;

   int   n_checks = 0;
   int   n_errs = 0;
   bit   cmp_on = 1'b0;

   rec_t exp_q[$];
   rec_t m_cur;
   rec_t m_r;
   bit   m_acc;
   logic m_err = 1'b0;
   int   m_accepts = 0;
   int   m_cyc = 0;
   int   m_last_acc = 0;
   rec_t c_e;
   rec_t c_g;

   always #5 clk = ~clk;

`ifdef BITMEM_LOADER_VERIFY_EN
   logic [AW-1:0] raddr_o;
   logic          rdata_i;
   logic          err_o;
   assign rdata_i   = mem[raddr_o] ^ (corrupt_en && (raddr_o == corrupt_addr));
   assign got_raddr = raddr_o;
   assign got_err   = err_o;
`else
   assign got_raddr = '0;
   assign got_err   = 1'b0;
`endif

   bitmem_loader dut (
      .clk        (clk),
      .rst_ni     (rst_ni),
      .in_valid_i (in_valid_i),
      .in_ready_o (in_ready_o),
      .in_data_i  (in_data_i),
      .in_mask_i  (in_mask_i),
      .wen_o      (wen_o),
      .waddr_o    (waddr_o),
      .wdata_o    (wdata_o),
      .busy_o     (busy_o),
`ifdef BITMEM_LOADER_VERIFY_EN
      .raddr_o    (raddr_o),
      .rdata_i    (rdata_i),
      .err_o      (err_o),
`endif
      .done_o     (done_o)
   );

   // The bit memory being filled; contents survive loader reset.
   always @(posedge clk) begin
      if (wen_o === 1'b1) mem[waddr_o] <= wdata_o;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s got=%h expected=%h at t=%0t", name, got, exp, $time);
      end
   endtask

   function automatic rec_t idle_rec();
      rec_t r;
      r         = '0;
      r.ready   = 1'b1;
      r.chk_err = 1'b1;
      r.err     = m_err;
      return r;
   endfunction

   // Reference: each accepted word becomes a queue of per-cycle expected outputs.
   always @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         exp_q.delete();
         m_err = 1'b0;
      end else begin
         m_cyc++;
         m_cur = (exp_q.size() != 0) ? exp_q[0] : idle_rec();
         m_acc = m_cur.ready && (in_valid_i === 1'b1);
         if (exp_q.size() != 0) begin
            if (m_cur.wen) ref_mem[m_cur.waddr] = m_cur.wdata;
            if (m_cur.done) m_err = m_cur.err;
            void'(exp_q.pop_front());
         end
         if (m_acc) begin
            m_accepts++;
            m_last_acc = m_cyc;
            for (int k = 0; k < WW; k++) begin
               m_r         = '0;
               m_r.busy    = 1'b1;
               m_r.wen     = in_mask_i[k];
               m_r.waddr   = AW'(k);
               m_r.wdata   = in_data_i[k];
               m_r.chk_err = 1'b1;
               exp_q.push_back(m_r);
            end
            if (VERIFY) begin
               for (int k = 0; k < WW; k++) begin
                  m_r       = '0;
                  m_r.busy  = 1'b1;
                  m_r.raddr = AW'(k);
                  exp_q.push_back(m_r);
               end
            end
            m_r         = '0;
            m_r.ready   = 1'b1;
            m_r.done    = 1'b1;
            m_r.chk_err = 1'b1;
            m_r.err     = VERIFY && corrupt_en && in_mask_i[corrupt_addr];
            exp_q.push_back(m_r);
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_on) begin
         c_e = (exp_q.size() != 0) ? exp_q[0] : idle_rec();
         c_g         = '0;
         c_g.ready   = in_ready_o;
         c_g.busy    = busy_o;
         c_g.wen     = wen_o;
         c_g.waddr   = waddr_o;
         c_g.wdata   = wdata_o;
         c_g.raddr   = got_raddr;
         c_g.done    = done_o;
         c_g.chk_err = c_e.chk_err;
         c_g.err     = c_e.chk_err ? got_err : 1'b0;
         check($sformatf("cycle_outputs cyc=%0d", m_cyc), 32'(c_g), 32'(c_e));
         if (c_e.done) check("mem_at_done", 32'(mem), 32'(ref_mem));
      end
   end

   task automatic send_word(input logic [WW-1:0] d, input logic [WW-1:0] m, input bit keep);
      int start;
      int n;
      start      = m_accepts;
      in_valid_i = 1'b1;
      in_data_i  = d;
      in_mask_i  = m;
      n = 0;
      while (m_accepts == start && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("word_accepted", 32'(m_accepts != start), 32'd1);
      if (!keep) in_valid_i = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("word_completed", 32'(exp_q.size() == 0), 32'd1);
   endtask

   initial begin
      int a1;
      int a2;
      logic [WW-1:0] d;
      logic [WW-1:0] m;
      bit keep;

      repeat (3) @(posedge clk);
      #1;
      rst_ni = 1'b1;
      cmp_on = 1'b1;
      check("rst_ready", 32'(in_ready_o), 32'd1);
      check("rst_wen", 32'(wen_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_waddr", 32'(waddr_o), 32'd0);
      check("rst_err", 32'(got_err), 32'd0);

      send_word(16'hA5C3, 16'hFFFF, 1'b0);
      wait_idle();
      check("mem_a5c3", 32'(mem), 32'h0000_A5C3);

      send_word(16'h0000, 16'hFFFF, 1'b0);
      wait_idle();
      send_word(16'hFFFF, 16'h00F0, 1'b0);
      wait_idle();
      check("mem_masked_00f0", 32'(mem), 32'h0000_00F0);

      send_word(16'h1234, 16'h0000, 1'b0);
      wait_idle();
      check("mem_zero_mask", 32'(mem), 32'h0000_00F0);

      send_word(16'h3C3C, 16'hFFFF, 1'b1);
      a1 = m_last_acc;
      send_word(16'hC0DE, 16'hFF00, 1'b0);
      a2 = m_last_acc;
      check("b2b_accept_gap", 32'(a2 - a1), 32'(LAT));
      wait_idle();
      check("mem_b2b", 32'(mem), 32'h0000_C03C);

      send_word(16'h0000, 16'hFFFF, 1'b0);
      wait_idle();
      send_word(16'hFFFF, 16'hFFFF, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      check("pre_rst_waddr", 32'(waddr_o), 32'd5);
      check("pre_rst_wen", 32'(wen_o), 32'd1);
      #1;
      rst_ni = 1'b0;
      #1;
      check("async_rst_wen", 32'(wen_o), 32'd0);
      check("async_rst_busy", 32'(busy_o), 32'd0);
      @(posedge clk);
      #1;
      rst_ni = 1'b1;
      check("mem_after_abort", 32'(mem), 32'h0000_001F);
      send_word(16'hA5C3, 16'hFFFF, 1'b0);
      wait_idle();
      check("mem_after_rst_word", 32'(mem), 32'h0000_A5C3);

      for (int i = 0; i < 25; i++) begin
         d = WW'($urandom);
         case ($urandom_range(0, 5))
            0:       m = '0;
            1:       m = '1;
            default: m = WW'($urandom);
         endcase
         keep = (i != 24) && ($urandom_range(0, 1) == 1);
         send_word(d, m, keep);
         if (!keep) repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
         end
      end
      wait_idle();
      check("mem_random_final", 32'(mem), 32'(ref_mem));

`ifdef BITMEM_LOADER_VERIFY_EN
      corrupt_en   = 1'b1;
      corrupt_addr = 4'd9;
      send_word(16'hFFFF, 16'h0200, 1'b0);
      wait_idle();
      check("err_set_bit9", 32'(err_o), 32'd1);
      send_word(16'hFFFF, 16'hFDFF, 1'b0);
      check("err_clear_on_accept", 32'(err_o), 32'd0);
      wait_idle();
      check("err_masked_bit9", 32'(err_o), 32'd0);
      corrupt_en = 1'b0;
`endif

      repeat (2) @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout got=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/bitmem_loader.md
# bitmem_loader

Upstream write sequencer for the 16-entry, 1-bit-wide multidimensional bit memory. Accepts a 16-bit word plus a 16-bit write mask over a valid/ready handshake, then serialises it into one memory write per cycle on the memory's `wen/waddr/wdata` port. It lets a word-oriented producer fill the bit memory without knowing its bit-level addressing. An optional read-back check compares every written bit against the memory's read port.

## Interface
- `ADDR_W`, 4, memory address width; must equal the memory's address width.
- `WORD_W`, `2**ADDR_W` (16), word/mask width; one bit per memory entry.
- `clk`  in  1  clock, rising edge
- `rst_ni`  in  1  reset, asynchronous, active-low
- `in_valid_i`  in  1  word/mask offered
- `in_ready_o`  out  1  loader can accept; high only in IDLE
- `in_data_i`  in  WORD_W  bit i goes to memory address i
- `in_mask_i`  in  WORD_W  bit i = 1: address i is written; 0: skipped
- `wen_o`  out  1  memory write enable
- `waddr_o`  out  ADDR_W  memory write address
- `wdata_o`  out  1  memory write data
- `busy_o`  out  1  state is not IDLE
- `done_o`  out  1  one-cycle pulse when a word is finished
- `raddr_o`  out  ADDR_W  memory read address (only with `BITMEM_LOADER_VERIFY_EN`)
- `rdata_i`  in  1  memory read data, combinational from `raddr_o` (only with `BITMEM_LOADER_VERIFY_EN`)
- `err_o`  out  1  sticky read-back mismatch (only with `BITMEM_LOADER_VERIFY_EN`)

## Operation
- States: IDLE, WRITE, CHECK. CHECK exists only with the macro.
- IDLE:
  - `in_ready_o`=1.
  - On `in_valid_i && in_ready_o`: latch `data_q` and `mask_q`, set `cnt`=0, clear `err_o`, go to WRITE.
- WRITE, cycle k (k = `cnt`, 0..15):
  - `waddr_o`=k, `wdata_o`=`data_q[k]`, `wen_o`=`mask_q[k]`.
  - Masked-off addresses still take their cycle, so the sequence is always 16 cycles.
  - At k=15, `cnt` wraps to 0. Next state is CHECK with the macro, otherwise IDLE.
- CHECK, cycle k:
  - `raddr_o`=k.
  - If `mask_q[k]` and `rdata_i != data_q[k]`, set `err_o`. It stays set until the next accept.
  - At k=15, go to IDLE.
- `done_o` is registered. It is high for exactly the first IDLE cycle after WRITE (or CHECK) completes.
- All outputs decode from registers only. There is no combinational path from any `in_*` input to any output.
- Outside WRITE: `wen_o`=0, `waddr_o`=0, `wdata_o`=0.
- Outside CHECK: `raddr_o`=0.
- Reset values: state IDLE, `cnt`=0, `data_q`=0, `mask_q`=0, `in_ready_o`=1, `busy_o`=0, `done_o`=0, `err_o`=0.
- Reset mid-operation:
  - The state returns to IDLE immediately and asynchronously, and `wen_o` drops the same instant.
  - Memory entries already written keep their values; there is no rollback.
- Mask of all zeros: the full 16-cycle WRITE still runs with `wen_o`=0 throughout, and `done_o` still pulses.
- `in_valid_i` while busy: ignored. The producer must hold it, and it is accepted in the IDLE cycle that carries `done_o`.

## Timing
- Accept at edge T0. WRITE cycles are T0+1..T0+16.
- `done_o` is at T0+17 without the macro and at T0+33 with it.
- Back-to-back words: one word per 17 (or 33) cycles.
- The memory commits write k at the end of WRITE cycle k. CHECK cycle 0 therefore starts after all writes have landed, so every read-back sees the final contents.
- `err_o` is valid when `done_o` is high and holds until the next accept edge.

## Configuration
- Macro: `BITMEM_LOADER_VERIFY_EN`.
- Defined:
  - The CHECK state and the `raddr_o`, `rdata_i`, `err_o` ports exist.
  - Latency is 33 cycles per word.
- Undefined:
  - Those three ports and the CHECK state are absent.
  - WRITE goes directly to IDLE, and latency is 17 cycles per word.

## Structure
- Package `bitmem_pkg`:
  - localparams `BITMEM_ADDR_W`=4 and `BITMEM_WORD_W`=16;
  - enum `bitmem_loader_state_e` {IDLE, WRITE, CHECK}.
- No sub-module. The counter, FSM and check logic stay inline.
- The bench instantiates this block driving the bit memory, with `raddr_o`/`rdata_i` connected to the memory's read port.

## Test plan
- Reset release → `in_ready_o`=1; `wen_o`, `busy_o`, `done_o`, `err_o`=0; `waddr_o`=0.
- `in_data_i`=16'hA5C3, mask 16'hFFFF → `wen_o`=1 for 16 cycles, `waddr_o` 0..15, `wdata_o`=bit k. `done_o` pulses once, and reading the memory back gives A5C3.
- Memory preloaded to 0, then data 16'hFFFF with mask 16'h00F0 → `wen_o` high only at addresses 4..7. Memory reads back 16'h00F0.
- `in_valid_i` held high across two words → second word accepted exactly in the `done_o` cycle; no word is lost or duplicated.
- `rst_ni` asserted during WRITE cycle 5 → `wen_o`=0 and `busy_o`=0 immediately. The next word then completes all 16 writes.
- `BITMEM_LOADER_VERIFY_EN`:
  - bench forces `rdata_i` wrong at address 9 with mask bit 9 set → `err_o`=1 at `done_o`, cleared on the next accept;
  - same corruption with mask bit 9 clear → `err_o`=0.
